uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: the stage directly downstream of the transmit path, consuming the serial line that uart_tx drives.
- Recovers frames (1 start, NB_DATA data LSB-first, NB_STOP stop) using the 16x oversampling tick from baudrate_generator.
- Presents each received byte as a one-cycle valid pulse with error flags.
- Instantiated beside uart_tx in the UART top level and shares the same baudrate_generator tick.

Parameters:
- NB_DATA, 8, data bits per frame.
- NB_STOP, 1, stop bits per frame (1 or 2).
- NB_DATA_COUNTER, $clog2(NB_DATA), width of the received-bit counter.
- NB_OVERSAMPLE, 4, width of the oversample counter; counts 0..15.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_tick  in  1  one-cycle pulse at 16x baud from baudrate_generator.
- i_data  in  1  asynchronous serial line; idles high.
- o_data  out  NB_DATA  last received byte; held until the next frame completes.
- o_valid  out  1  one-cycle pulse when a frame completes.
- o_frame_error  out  1  valid only with o_valid; 1 if any stop-bit sample was 0.
- o_parity_error  out  1  valid only with o_valid; see Optional Feature.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_reset==0 at a clock edge):
  - State = IDLE; counters = 0; shift register = 0.
  - 2-FF synchronizer flops = 1; line_armed = 1.
  - o_data=0, o_valid=0, o_frame_error=0, o_parity_error=0, o_busy=0.
  - Reset mid-frame aborts the frame silently; no o_valid is produced.
- Input path: i_data passes through a 2-FF synchronizer (rx_s). All decisions use rx_s. Added latency: 2 clocks.
- Counters advance only on cycles with i_tick==1; cycles without a tick hold all state, except the IDLE detection below.
- IDLE:
  - If rx_s==1, set line_armed=1.
  - If line_armed and rx_s==0, go to START with tick_cnt=0. This check is evaluated every clock, not tick-gated.
- START:
  - Tick at tick_cnt==7 (mid start bit): if rx_s==0, go to DATA with tick_cnt=0, bit_cnt=0.
  - If rx_s==1 at that point (glitch), return to IDLE with no output.
  - Otherwise tick_cnt++.
- DATA:
  - Tick at tick_cnt==15: shift rx_s into the MSB of the shift register (shift right, so LSB-first on the line ends up in bit 0), tick_cnt=0.
  - If bit_cnt==NB_DATA-1, go to PARITY (macro on) or STOP (macro off); else bit_cnt++.
  - Otherwise tick_cnt++.
- PARITY (macro only): tick at tick_cnt==15 samples the parity bit, tick_cnt=0, go to STOP.
- STOP:
  - Tick at tick_cnt==15 samples a stop bit; any 0 sample sets a sticky ferr.
  - After the last of NB_STOP samples:
    - o_data <= shift register.
    - o_valid=1 for exactly one clock.
    - o_frame_error <= ferr; o_parity_error <= perr.
    - Go to IDLE; line_armed <= !ferr.
- Framing-error case (line stuck low / break): IDLE accepts no new start until rx_s has been seen high.
- Frame completion occurs at mid final stop bit, so a back-to-back next start bit is never missed.
- o_frame_error and o_parity_error are 0 whenever o_valid==0.
- There is no backpressure: the consumer must capture o_data on o_valid. o_data is stable until the next o_valid.
- i_tick asserted on consecutive cycles is legal; every tick counts.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits; the PARITY state is present.
  - perr = XOR(data bits, parity sample).
  - o_parity_error reports perr with o_valid.
- Undefined:
  - No PARITY state; frame is start + data + stop.
  - o_parity_error is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset, then 8N1 frame 0xA5 at 9600 baud, 100 MHz, tick every 651 clocks → exactly one o_valid pulse, o_data=0xA5, o_frame_error=0, o_busy high from start detect until the pulse.
- Line low for 4 ticks then high (glitch) → no o_valid, FSM back in IDLE, o_busy=0 within 8 ticks of the low edge.
- Frame 0x3C with stop bit driven 0, then line held low for 3 frame times → one o_valid with o_data=0x3C and o_frame_error=1, no further o_valid until the line returns high; a following 0x55 frame is received correctly.
- Assert i_reset=0 for one clock after the 3rd data bit of 0x81, then send 0x81 → no o_valid for the aborted frame, all outputs 0 after reset, exactly one o_valid with o_data=0x81 for the new frame.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two o_valid pulses ~10 bit times apart, o_data=0x00 then 0xFF, both o_frame_error=0.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 0 → o_parity_error=1; 0x07 with parity bit 1 → o_parity_error=0. Macro undefined: o_parity_error stays 0 for all frames.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, oversample tick and received-byte outputs of uart_rx
interface uart_rx_if #(
  parameter int NB_DATA = 8
);
  logic i_tick;
  logic i_data;
  logic [NB_DATA-1:0] o_data;
  logic o_valid;
  logic o_frame_error;
  logic o_parity_error;
  logic o_busy;
  modport master (
    output i_tick, i_data,
    input  o_data, o_valid, o_frame_error, o_parity_error, o_busy
  );
  modport slave (
    input  i_tick, i_data,
    output o_data, o_valid, o_frame_error, o_parity_error, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx #(
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int NB_DATA_COUNTER = $clog2(NB_DATA),
  parameter int NB_OVERSAMPLE   = 4
) (
  input logic      i_clock,
  input logic      i_reset,
  uart_rx_if.slave bus
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [NB_OVERSAMPLE-1:0] tick_cnt, tick_cnt_n;
  logic [NB_DATA_COUNTER-1:0] bit_cnt, bit_cnt_n;
  logic [1:0] stop_cnt, stop_cnt_n;
  logic [NB_DATA-1:0] shreg, shreg_n, data_q, data_n;
  logic ferr, ferr_n, perr, perr_n, armed, armed_n;
  logic valid_q, valid_n, fe_q, fe_n, pe_q, pe_n;
  logic mid, stop_bad;
  assign rx_s     = sync[1];
  assign mid      = bus.i_tick && tick_cnt == '1;
  assign stop_bad = ferr | ~rx_s;
  // synchronizer and all receiver state; a low reset aborts any frame in flight
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync     <= '1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      shreg    <= '0;
      data_q   <= '0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      armed    <= 1'b1;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      sync     <= {sync[0], bus.i_data};
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      shreg    <= shreg_n;
      data_q   <= data_n;
      ferr     <= ferr_n;
      perr     <= perr_n;
      armed    <= armed_n;
      valid_q  <= valid_n;
      fe_q     <= fe_n;
      pe_q     <= pe_n;
    end
  end
  // frame FSM: start detect every clock, mid-bit sampling on ticks, result published at mid final stop bit
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    data_n     = data_q;
    ferr_n     = ferr;
    perr_n     = perr;
    armed_n    = armed;
    valid_n    = 1'b0;
    fe_n       = 1'b0;
    pe_n       = 1'b0;
    case (state)
      IDLE: begin
        armed_n = armed | rx_s;
        if (armed && !rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
          stop_cnt_n = '0;
          ferr_n     = 1'b0;
          perr_n     = 1'b0;
        end
      end
      START: if (bus.i_tick) begin
        if (tick_cnt == NB_OVERSAMPLE'(7)) begin
          state_n    = rx_s ? IDLE : DATA;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
        end else tick_cnt_n = tick_cnt + 1'b1;
      end
      DATA: if (bus.i_tick) begin
        tick_cnt_n = tick_cnt + 1'b1;
        if (mid) begin
          shreg_n   = {rx_s, shreg[NB_DATA-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == NB_DATA_COUNTER'(NB_DATA - 1)) state_n = PARITY;
`else
          if (bit_cnt == NB_DATA_COUNTER'(NB_DATA - 1)) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bus.i_tick) begin
        tick_cnt_n = tick_cnt + 1'b1;
        if (mid) begin
          perr_n  = ^{shreg, rx_s};
          state_n = STOP;
        end
      end
`endif
      STOP: if (bus.i_tick) begin
        tick_cnt_n = tick_cnt + 1'b1;
        if (mid) begin
          ferr_n     = stop_bad;
          stop_cnt_n = stop_cnt + 1'b1;
          if (stop_cnt == 2'(NB_STOP - 1)) begin
            data_n  = shreg;
            valid_n = 1'b1;
            fe_n    = stop_bad;
            pe_n    = perr;
            state_n = IDLE;
            armed_n = ~stop_bad;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.o_data         = data_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_frame_error  = fe_q;
  assign bus.o_parity_error = pe_q;
  assign bus.o_busy         = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, directed and randomized frames checked against a frame-level receive model
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if #(.NB_DATA(8)) bus();
  uart_rx dut (.i_clock(clk), .i_reset(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic fe; logic pe; int t;} rec_t;
  typedef struct {logic [7:0] d; logic stop; logic par; int gap; logic efe; logic epe;} vec_t;
  rec_t got[$];
  vec_t tbl[8];
  int checks = 0, failures = 0, rd = 0, per = 4, tick_total = 0;
  logic bad_idle = 1'b0;

  // tick generator: one pulse every per clocks, tick_total counts ticks seen by the DUT
  initial begin
    int cnt;
    cnt = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_total += int'(bus.i_tick);
      if (cnt >= per - 1) begin
        bus.i_tick = 1'b1;
        cnt = 0;
      end else begin
        bus.i_tick = 1'b0;
        cnt++;
      end
    end
  end

  // capture every received frame; flag errors reported without valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid) got.push_back('{bus.o_data, bus.o_frame_error, bus.o_parity_error, tick_total});
      else if (bus.o_frame_error || bus.o_parity_error) bad_idle = 1'b1;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic wait_ticks(input int n);
    int tgt;
    tgt = tick_total + n;
    while (tick_total < tgt) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    bus.i_data = v;
    wait_ticks(16);
  endtask

  task automatic frame_body(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.i_data = 1'b1;
    wait_ticks(n);
  endtask

  task automatic expect_frame(input string n, input logic [7:0] d, input logic fe, input logic pe);
    int w;
    w = 0;
    while (got.size() <= rd && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (got.size() <= rd) chk({n, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({n, "_data"}, got[rd].d, d);
      chk({n, "_ferr"}, got[rd].fe, fe);
      chk({n, "_perr"}, got[rd].pe, pe);
      rd++;
    end
  endtask

  task automatic outputs_zero(input string n);
    chk({n, "_data"}, bus.o_data, 0);
    chk({n, "_valid"}, bus.o_valid, 0);
    chk({n, "_busy"}, bus.o_busy, 0);
    chk({n, "_ferr"}, bus.o_frame_error, 0);
    chk({n, "_perr"}, bus.o_parity_error, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic stop, par;
    int gap, b2b;
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b1, 1'b0, 8, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b0, 8, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b0, 8, 1'b0, PAR_EN};
    tbl[5] = '{8'h07, 1'b1, 1'b1, 8, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 1'b0, 1'b0, 8, 1'b1, 1'b0};
    tbl[7] = '{8'h1E, 1'b1, 1'b1, 8, 1'b0, PAR_EN};
    bus.i_data = 1'b1;
    repeat (4) @(negedge clk);
    outputs_zero("reset");
    rst_n = 1'b1;
    idle(4);

    send_bit(1'b0);
    chk("a5_busy_in_frame", bus.o_busy, 1);
    for (int i = 0; i < 8; i++) send_bit(tbl[0].d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    idle(4);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_busy_after", bus.o_busy, 0);
    chk("a5_count", got.size(), rd);

    bus.i_data = 1'b0;
    wait_ticks(2);
    chk("glitch_busy", bus.o_busy, 1);
    wait_ticks(2);
    bus.i_data = 1'b1;
    wait_ticks(6);
    chk("glitch_idle", bus.o_busy, 0);
    idle(20);
    chk("glitch_no_valid", got.size(), rd);

    b2b = 0;
    foreach (tbl[k]) begin
      frame_body(tbl[k].d, tbl[k].stop, tbl[k].par);
      if (tbl[k].gap > 0) idle(tbl[k].gap);
      expect_frame($sformatf("tbl%0d", k), tbl[k].d, tbl[k].efe, tbl[k].epe);
      if (k == 3) b2b = rd;
    end
    if (b2b >= 2) begin
      chk("b2b_spacing_lo", got[b2b-1].t - got[b2b-2].t >= 156, 1);
      chk("b2b_spacing_hi", got[b2b-1].t - got[b2b-2].t <= 164, 1);
    end

    frame_body(8'h3C, 1'b0, 1'b0);
    wait_ticks(480);
    expect_frame("break", 8'h3C, 1'b1, 1'b0);
    chk("break_no_valid", got.size(), rd);
    chk("break_not_busy", bus.o_busy, 0);
    idle(16);
    frame_body(8'h55, 1'b1, 1'b0);
    idle(8);
    expect_frame("after_break", 8'h55, 1'b0, 1'b0);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i == 0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_data = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    outputs_zero("midreset");
    idle(160);
    chk("midreset_no_valid", got.size(), rd);
    frame_body(8'h81, 1'b1, 1'b0);
    idle(8);
    expect_frame("after_reset", 8'h81, 1'b0, 1'b0);
    chk("after_reset_count", got.size(), rd);

    for (int n = 0; n < 30; n++) begin
      per  = $urandom_range(1, 4);
      d    = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      par  = 1'($urandom);
      gap  = $urandom_range(0, 20);
      if (!stop && gap < 4) gap = 4;
      frame_body(d, stop, par);
      if (gap > 0) idle(gap);
      expect_frame($sformatf("rand%0d", n), d, !stop, PAR_EN ? (^d ^ par) : 1'b0);
    end
    per = 4;
    idle(40);
    chk("final_count", got.size(), rd);
    chk("flags_only_with_valid", bad_idle, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
